// File: rtl/spi_pkg.sv
// Shared types and mode encodings for the SPI peripheral core.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int unsigned CPOL_LOW   = 0;
    localparam int unsigned CPOL_HIGH  = 1;
    localparam int unsigned CPHA_LEAD  = 0;
    localparam int unsigned CPHA_TRAIL = 1;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for one asynchronous pin plus rise/fall detection
// on the synchronised level.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= {3{RST_VAL}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign level  = pipe_q[1];
    assign rise_c = pipe_q[1] & ~pipe_q[2];
    assign fall_c = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_peripheral_core.sv
// SPI peripheral (slave) core with TX/RX word handshakes and sticky error flags.
// Define SPI_PERIPH_RX_FIFO_EN to replace the RX holding register with an RX_DEPTH FIFO.
module spi_peripheral_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun,
    input  logic              err_clr,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_rise_c, sck_fall_c, ss_rise_c, ss_fall_c, mosi_s;
    logic sck_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused;
    logic lead_c, trail_c, sample_c, shift_c;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic              miso_q, miso_d, fresh_q, fresh_d;
    logic              tx_ready_q, tx_ready_d, overrun_q, overrun_d, underrun_q, underrun_d;
    logic              load_c, word_done_c, overrun_set_c;
    logic [DATA_W-1:0] rx_word_c, load_word_c;

    spi_edge_sync #(.RST_VAL(1'(CPOL == CPOL_HIGH))) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck),
        .level(sck_lvl_unused), .rise_c(sck_rise_c), .fall_c(sck_fall_c));
    spi_edge_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .din(ss_n),
        .level(ss_lvl_unused), .rise_c(ss_rise_c), .fall_c(ss_fall_c));
    spi_edge_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused));

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    // Map mode onto sample/shift edges of the synchronised clock.
    always_comb begin
        lead_c   = (CPOL == CPOL_HIGH) ? sck_fall_c : sck_rise_c;
        trail_c  = (CPOL == CPOL_HIGH) ? sck_rise_c : sck_fall_c;
        sample_c = (CPHA == CPHA_TRAIL) ? trail_c : lead_c;
        shift_c  = (CPHA == CPHA_TRAIL) ? lead_c : trail_c;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        fresh_d     = fresh_q;
        load_c      = 1'b0;
        word_done_c = 1'b0;
        rx_word_c   = shift_in(rx_sh_q, mosi_s);
        load_word_c = tx_valid ? tx_data : '0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    load_c    = 1'b1;
                    // CPHA=1 holds the word until the first leading edge drives bit 0.
                    if (CPHA == CPHA_TRAIL) begin
                        tx_sh_d = load_word_c;
                        miso_d  = 1'b0;
                        fresh_d = 1'b1;
                    end else begin
                        tx_sh_d = shift_in(load_word_c, 1'b0);
                        miso_d  = first_bit(load_word_c);
                    end
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_c) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    tx_sh_d   = '0;
                    miso_d    = 1'b0;
                    fresh_d   = 1'b0;
                end else begin
                    if (sample_c) begin
                        rx_sh_d = rx_word_c;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = '0;
                            word_done_c = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // A shift edge at bit 0 of a follow-on word reloads from tx_data.
                    if (shift_c) begin
                        fresh_d = 1'b0;
                        if (bit_cnt_q == '0 && (CPHA == CPHA_LEAD || !fresh_q)) begin
                            load_c  = 1'b1;
                            miso_d  = first_bit(load_word_c);
                            tx_sh_d = shift_in(load_word_c, 1'b0);
                        end else begin
                            miso_d  = first_bit(tx_sh_q);
                            tx_sh_d = shift_in(tx_sh_q, 1'b0);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready_d = load_c & tx_valid;
        overrun_d  = overrun_set_c ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
        underrun_d = (load_c & ~tx_valid) ? 1'b1 : (err_clr ? 1'b0 : underrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b0;
            fresh_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            miso_q     <= miso_d;
            fresh_q    <= fresh_d;
            tx_ready_q <= tx_ready_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef SPI_PERIPH_RX_FIFO_EN
    localparam int unsigned PTR_W  = $clog2(RX_DEPTH);
    localparam int unsigned PTR_AW = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic [DATA_W-1:0] mem_d [RX_DEPTH];
    logic [PTR_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              full_c, empty_c;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        empty_c       = (wr_ptr_q == rd_ptr_q);
        full_c        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        overrun_set_c = word_done_c & full_c;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (word_done_c && !full_c) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = rx_word_c;
            wr_ptr_d = wr_ptr_q + PTR_AW'(1);
        end
        if (!empty_c && rx_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RX_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign rx_valid = ~empty_c;
    assign rx_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
`else
    localparam int unsigned RX_DEPTH_UNUSED = RX_DEPTH;

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    // Single holding register; a new word is dropped only if the old one is not being taken.
    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        overrun_set_c = word_done_c & hold_valid_q & ~rx_ready;
        if (hold_valid_q && rx_ready) begin
            hold_valid_d = 1'b0;
        end
        if (word_done_c && !overrun_set_c) begin
            hold_valid_d = 1'b1;
            hold_data_d  = rx_word_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign rx_valid = hold_valid_q;
    assign rx_data  = hold_data_q;
`endif

    assign busy     = (state_q == ST_ACTIVE);
    assign miso_oe  = busy;
    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral_core.sv
// Directed bench: mode-0 8-bit MSB-first core (u_a) and mode-3 16-bit LSB-first core (u_b).
module tb_spi_peripheral_core;

    localparam int unsigned HALF = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        sck_a, ss_a, mosi_a, miso_a, miso_oe_a;
    logic [7:0]  tx_data_a, rx_data_a;
    logic        tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic        overrun_a, underrun_a, err_clr_a, busy_a;

    logic        sck_b, ss_b, mosi_b, miso_b, miso_oe_b;
    logic [15:0] tx_data_b, rx_data_b;
    logic        tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic        overrun_b, underrun_b, err_clr_b, busy_b;

    spi_peripheral_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .RX_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .sck(sck_a), .ss_n(ss_a), .mosi(mosi_a),
        .miso(miso_a), .miso_oe(miso_oe_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .overrun(overrun_a), .underrun(underrun_a), .err_clr(err_clr_a), .busy(busy_a));

    spi_peripheral_core #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .RX_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .sck(sck_b), .ss_n(ss_b), .mosi(mosi_b),
        .miso(miso_b), .miso_oe(miso_oe_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .overrun(overrun_b), .underrun(underrun_b), .err_clr(err_clr_b), .busy(busy_b));

    int errors = 0;
    int checks = 0;
    int txr_hi_b = 0;

    always @(posedge clk) begin
        if (tx_ready_b === 1'b1) txr_hi_b++;
    end

    typedef struct packed {
        logic [7:0] mo;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_sck(input bit sel, input logic v);
        if (sel) sck_b = v; else sck_a = v;
    endtask

    task automatic drive_mosi(input bit sel, input logic v);
        if (sel) mosi_b = v; else mosi_a = v;
    endtask

    task automatic ss_low(input bit sel);
        @(negedge clk);
        if (sel) ss_b = 1'b0; else ss_a = 1'b0;
        #HALF;
    endtask

    task automatic ss_high(input bit sel);
        #HALF;
        if (sel) ss_b = 1'b1; else ss_a = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master side of one word; nbits below the word length gives a partial word.
    task automatic frame_word(input bit sel, input int nbits, input logic [31:0] mo,
                              output logic [31:0] mi);
        bit cpol, cpha, msb;
        int dw;
        cpol = sel; cpha = sel; msb = !sel; dw = sel ? 16 : 8;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = msb ? dw - 1 - i : i;
            if (!cpha) begin
                drive_mosi(sel, mo[idx]);
                #HALF;
                drive_sck(sel, !cpol);
                mi[idx] = sel ? miso_b : miso_a;
                #HALF;
                drive_sck(sel, cpol);
            end else begin
                drive_sck(sel, !cpol);
                drive_mosi(sel, mo[idx]);
                #HALF;
                drive_sck(sel, cpol);
                mi[idx] = sel ? miso_b : miso_a;
                #HALF;
            end
        end
    endtask

    task automatic run_a(input logic [7:0] mo, output logic [7:0] mi);
        logic [31:0] m;
        ss_low(1'b0);
        frame_word(1'b0, 8, {24'h0, mo}, m);
        ss_high(1'b0);
        mi = m[7:0];
    endtask

    task automatic pop(input bit sel);
        @(negedge clk);
        if (sel) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
        @(negedge clk);
        if (sel) rx_ready_b = 1'b0; else rx_ready_a = 1'b0;
    endtask

    task automatic pulse_clr_a();
        @(negedge clk);
        err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [4];
        logic [7:0]  mi8;
        logic [31:0] m;
        int          txr0;

        vecs[0] = '{mo: 8'hA5, tx: 8'h3C, exp_rx: 8'hA5, exp_mi: 8'h3C};
        vecs[1] = '{mo: 8'hFF, tx: 8'h00, exp_rx: 8'hFF, exp_mi: 8'h00};
        vecs[2] = '{mo: 8'h00, tx: 8'hFF, exp_rx: 8'h00, exp_mi: 8'hFF};
        vecs[3] = '{mo: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_mi: 8'h7E};

        rst_n = 1'b0;
        sck_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0;
        tx_data_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b0; err_clr_a = 1'b0;
        sck_b = 1'b1; ss_b = 1'b1; mosi_b = 1'b0;
        tx_data_b = 16'h0; tx_valid_b = 1'b0; rx_ready_b = 1'b0; err_clr_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_miso", miso_a, 0);
        check("rst_miso_oe", miso_oe_a, 0);
        check("rst_tx_ready", tx_ready_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_overrun", overrun_a, 0);
        check("rst_underrun", underrun_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_rx_valid", rx_valid_b, 0);
        check("rst_b_busy", busy_b, 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 0 single-word frames
        tx_valid_a = 1'b1;
        for (int v = 0; v < 4; v++) begin
            tx_data_a = vecs[v].tx;
            run_a(vecs[v].mo, mi8);
            check($sformatf("v%0d_rx_valid", v), rx_valid_a, 1);
            check($sformatf("v%0d_rx_data", v), rx_data_a, vecs[v].exp_rx);
            check($sformatf("v%0d_master_rx", v), mi8, vecs[v].exp_mi);
            check($sformatf("v%0d_underrun", v), underrun_a, 0);
            pop(1'b0);
            check($sformatf("v%0d_rx_valid_after_pop", v), rx_valid_a, 0);
        end
        check("idle_miso_oe", miso_oe_a, 0);

        // Mode 3, 16-bit, LSB first
        tx_data_b = 16'hBEEF; tx_valid_b = 1'b1;
        txr0 = txr_hi_b;
        ss_low(1'b1);
        frame_word(1'b1, 16, 32'h1234, m);
        ss_high(1'b1);
        check("m3_rx_valid", rx_valid_b, 1);
        check("m3_rx_data", rx_data_b, 16'h1234);
        check("m3_master_rx", m[15:0], 16'hBEEF);
        check("m3_tx_ready_cycles", txr_hi_b - txr0, 1);
        check("m3_underrun", underrun_b, 0);
        pop(1'b1);
        check("m3_rx_valid_after_pop", rx_valid_b, 0);

        // Three back-to-back words with rx_ready held low
        tx_data_a = 8'h11;
        ss_low(1'b0);
        frame_word(1'b0, 8, 32'h01, m);
        frame_word(1'b0, 8, 32'h02, m);
        frame_word(1'b0, 8, 32'h03, m);
        ss_high(1'b0);
`ifdef SPI_PERIPH_RX_FIFO_EN
        check("b2b_overrun", overrun_a, 0);
        check("b2b_head0", rx_data_a, 8'h01);
        pop(1'b0);
        check("b2b_head1", rx_data_a, 8'h02);
        pop(1'b0);
        check("b2b_head2", rx_data_a, 8'h03);
        check("b2b_valid2", rx_valid_a, 1);
        pop(1'b0);
        check("b2b_empty", rx_valid_a, 0);
`else
        check("b2b_overrun", overrun_a, 1);
        check("b2b_rx_valid", rx_valid_a, 1);
        check("b2b_held", rx_data_a, 8'h01);
        pop(1'b0);
        check("b2b_empty", rx_valid_a, 0);
`endif
        pulse_clr_a();
        check("b2b_overrun_cleared", overrun_a, 0);

        // Frame aborted after 5 bits
        ss_low(1'b0);
        frame_word(1'b0, 5, 32'hFF, m);
        ss_high(1'b0);
        check("abort_rx_valid", rx_valid_a, 0);
        check("abort_bit_cnt", u_a.bit_cnt_q, 0);
        check("abort_overrun", overrun_a, 0);
        tx_data_a = 8'h66;
        run_a(8'h5A, mi8);
        check("abort_next_rx", rx_data_a, 8'h5A);
        check("abort_next_valid", rx_valid_a, 1);
        check("abort_next_master", mi8, 8'h66);
        pop(1'b0);

        // Underrun: no TX word at word start
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hFF;
        run_a(8'h33, mi8);
        check("ur_master_rx", mi8, 8'h00);
        check("ur_underrun", underrun_a, 1);
        check("ur_rx_data", rx_data_a, 8'h33);
        pulse_clr_a();
        check("ur_cleared", underrun_a, 0);
        pop(1'b0);
        tx_valid_a = 1'b1;

        // Reset asserted mid-word
        tx_data_a = 8'hFF;
        ss_low(1'b0);
        frame_word(1'b0, 3, 32'hF0, m);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", miso_a, 0);
        check("mid_rst_miso_oe", miso_oe_a, 0);
        check("mid_rst_tx_ready", tx_ready_a, 0);
        check("mid_rst_rx_valid", rx_valid_a, 0);
        check("mid_rst_rx_data", rx_data_a, 0);
        check("mid_rst_overrun", overrun_a, 0);
        check("mid_rst_underrun", underrun_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_bit_cnt", u_a.bit_cnt_q, 0);
        @(negedge clk);
        ss_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy_a, 0);
        tx_data_a = 8'h96;
        run_a(8'hC3, mi8);
        check("post_rst_rx", rx_data_a, 8'hC3);
        check("post_rst_valid", rx_valid_a, 1);
        check("post_rst_master", mi8, 8'h96);
        pop(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_core.md
SPI_PERIPHERAL_CORE -- requirements
Module: spi_peripheral_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word length in bits (2..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 0 = LSB first on both lines.
REQ-005 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries (power of two, at least 2; used only with SPI_PERIPH_RX_FIFO_EN).
REQ-006 SHALL have port clk, input, 1, system clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports sck, ss_n and mosi, each input, 1, asynchronous SPI pins.
REQ-009 SHALL have ports miso, output, 1, serial out; and miso_oe, output, 1, driver enable.
REQ-010 SHALL have ports tx_data, input, DATA_W; tx_valid, input, 1; tx_ready, output, 1.
REQ-011 SHALL have ports rx_data, output, DATA_W; rx_valid, output, 1; rx_ready, input, 1.
REQ-012 SHALL have ports overrun and underrun, each output, 1, sticky error flags; err_clr, input, 1, clears both flags.
REQ-013 SHALL have port busy, output, 1, high while synchronised ss_n is low.

Function
REQ-014 SHALL pass sck, ss_n and mosi through 2-flop synchronisers, then detect edges on the synchronised sck; clk SHALL be at least 4x the SCK rate.
REQ-015 SHALL implement states IDLE and ACTIVE.
- IDLE -> ACTIVE on a synchronised ss_n fall.
- ACTIVE -> IDLE on a synchronised ss_n rise.
REQ-016 SHALL, in ACTIVE, shift mosi into the RX shifter on each sample edge and advance miso on each shift edge (the opposite edge), honouring MSB_FIRST.
REQ-017 SHALL count sample edges in a bit counter of width clog2(DATA_W); on the DATA_W-th edge it SHALL wrap to 0 and the word is complete; back-to-back words continue while ss_n stays low.
REQ-018 SHALL present a completed word on rx_data with rx_valid high in the clk cycle after the final sample edge is detected.
REQ-019 SHALL treat an rx_data transfer as accepted on a cycle with rx_valid and rx_ready both high.
REQ-020 SHALL drop a completed word that finds no free RX storage and set overrun; previously stored data is unchanged.
REQ-021 SHALL load the TX shifter at each word start (the ss_n fall, or the word boundary when ss_n stays low).
- tx_valid high: load tx_data and pulse tx_ready for exactly one cycle.
- tx_valid low: load all-zeros and set underrun.
REQ-022 SHALL, with CPHA=0, drive the first TX bit on miso on the cycle the TX shifter is loaded.
REQ-023 SHALL, on an ss_n rise mid-word, discard the partial word, clear the bit counter, push no rx data and set no flag.
REQ-024 SHALL drive miso_oe equal to busy, and miso low when miso_oe is low.
REQ-025 SHALL clear both flags when err_clr is high, except that a flag set event in the same cycle wins.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force state IDLE, bit counter 0, shifters 0 and synchronisers to idle (sck=CPOL, ss_n=1).
REQ-027 SHALL hold these output values during reset: miso=0, miso_oe=0, tx_ready=0, rx_valid=0, rx_data=0, overrun=0, underrun=0, busy=0; RX storage is emptied.
REQ-028 SHALL, if reset is asserted mid-frame, discard the frame; after reset release the block SHALL wait for a fresh ss_n fall.

Configuration
REQ-029 SHALL use macro SPI_PERIPH_RX_FIFO_EN.
- Defined: completed words enter an RX_DEPTH-entry FIFO; rx_data/rx_valid present the FIFO head; overrun is set only when the FIFO is full.
- Undefined: a single holding register is used; overrun is set when a word completes while rx_valid is high and rx_ready is low.

Structure
REQ-030 SHALL place the state enum (IDLE, ACTIVE) and the mode constants (CPOL/CPHA encodings) in package spi_pkg.
REQ-031 SHALL implement the synchroniser plus edge detector as sub-module spi_edge_sync, one instance per input pin.

Verification
REQ-032 SHALL cover mode 0, DATA_W=8: master sends 0xA5 while tx_data=0x3C is preloaded -> rx_data=0xA5 with a 1-cycle rx_valid handshake, and the master receives 0x3C.
REQ-033 SHALL cover mode 3, DATA_W=16, MSB_FIRST=0: master sends 0x1234 -> rx_data=0x1234 and tx_ready pulses once.
REQ-034 SHALL cover three back-to-back words 0x01, 0x02, 0x03 with rx_ready held low.
- FIFO enabled (RX_DEPTH=4): all three are held and overrun stays 0.
- FIFO disabled: 0x01 is held and overrun=1.
REQ-035 SHALL cover ss_n rising after 5 bits -> no rx_valid, bit counter 0; the next full frame 0x5A is received intact.
REQ-036 SHALL cover tx_valid low at word start -> master receives 0x00 and underrun=1; err_clr pulse -> underrun=0.
REQ-037 SHALL cover rst_n asserted mid-word -> all outputs take their reset values immediately; the next frame 0xC3 is received correctly.
